// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// Holds the FSM state enum, default width constants and the saturation helper.
package psum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int DEF_MESH_X  = 8;
  localparam int DEF_MESH_Y  = 8;
  localparam int DEF_OUT_BIT = 32;
  localparam int DEF_RES_BIT = 16;
  localparam int DEF_PASS_W  = 8;

  // Working width for saturation; wide enough for any OUT_BIT+1 intermediate.
  localparam int SAT_W = 64;

  // Clamp a signed value into the signed range of res_bit bits.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                  input int res_bit);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (res_bit - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (res_bit - 1));
    if (x > hi) begin
      sat = hi;
    end else if (x < lo) begin
      sat = lo;
    end else begin
      sat = x;
    end
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Per-lane requantizer: arithmetic right shift then saturate to RES_BIT.
// Optional macro PSUM_ROUND_EN adds 2^(shift-1) before shifting (round-half-up);
// without it the shift truncates toward negative infinity. Purely combinational.
module psum_requant
  import psum_pkg::*;
#(
  parameter int OUT_BIT = DEF_OUT_BIT,
  parameter int RES_BIT = DEF_RES_BIT
) (
  input  logic [OUT_BIT-1:0] sum_i,
  input  logic [4:0]         shift_i,
  output logic [RES_BIT-1:0] res_o
);

  logic signed [OUT_BIT:0]  ext;
  logic signed [OUT_BIT:0]  shifted;
  logic signed [SAT_W-1:0]  wide;
`ifdef PSUM_ROUND_EN
  logic [OUT_BIT:0]         bias;
`endif

  // Sign-extend by one bit so the rounding bias can never overflow, shift, then clamp.
  always_comb begin
    ext = {sum_i[OUT_BIT-1], sum_i};
`ifdef PSUM_ROUND_EN
    // (1 << shift) >> 1 yields 2^(shift-1) for shift>0 and 0 for shift==0.
    bias    = ({{OUT_BIT{1'b0}}, 1'b1} << shift_i) >> 1;
    shifted = (ext + $signed(bias)) >>> shift_i;
`else
    shifted = ext >>> shift_i;
`endif
    wide  = {{(SAT_W-OUT_BIT-1){shifted[OUT_BIT]}}, shifted};
    res_o = RES_BIT'(sat(wide, RES_BIT));
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator sitting behind the mesh adder tree.
// Feeds the running sum back as inter_data, counts passes per tile, and on the
// last pass requantizes the incoming tree sums into a held result.
// Build option: PSUM_ROUND_EN selects round-half-up requantization (see psum_requant).
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int MESH_X  = DEF_MESH_X,
  parameter int MESH_Y  = DEF_MESH_Y,
  parameter int OUT_BIT = DEF_OUT_BIT,
  parameter int RES_BIT = DEF_RES_BIT,
  parameter int PASS_W  = DEF_PASS_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [PASS_W-1:0]           cfg_passes,
  input  logic [4:0]                  cfg_shift,
  input  logic                        sum_valid,
  input  logic [MESH_X*MESH_Y*OUT_BIT-1:0] sum_data,
  output logic                        sum_ready,
  output logic [MESH_X*MESH_Y*OUT_BIT-1:0] inter_data,
  output logic                        res_valid,
  output logic [MESH_X*MESH_Y*RES_BIT-1:0] res_data,
  input  logic                        res_ready,
  output logic                        busy
);

  localparam int L = MESH_X * MESH_Y;

  state_e                 state_q, state_d;
  logic [PASS_W-1:0]      pass_cnt_q, pass_cnt_d;
  logic [L*OUT_BIT-1:0]   acc_q, acc_d;
  logic [PASS_W-1:0]      passes_q, passes_d;
  logic [4:0]             shift_q, shift_d;
  logic [L*RES_BIT-1:0]   res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;

  logic                   first_pass;
  logic                   last_pass;
  logic                   accept;
  logic [PASS_W-1:0]      cfg_passes_norm;
  logic [PASS_W-1:0]      passes_eff;
  logic [4:0]             shift_eff;
  logic [L*RES_BIT-1:0]   res_lanes;

  // On the first pass the live config applies; afterwards the shadowed copy does.
  assign first_pass      = (pass_cnt_q == '0);
  assign cfg_passes_norm = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
  assign passes_eff      = first_pass ? cfg_passes_norm : passes_q;
  assign shift_eff       = first_pass ? cfg_shift : shift_q;
  assign last_pass       = (pass_cnt_q == passes_eff - PASS_W'(1));

  assign sum_ready  = ena & ((state_q == ACCUM) | res_ready);
  assign accept     = sum_valid & sum_ready;
  assign inter_data = first_pass ? '0 : acc_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = ~first_pass | res_valid_q;

  // The result is taken straight from the final tree sums, so no extra latency.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    psum_requant #(
      .OUT_BIT(OUT_BIT),
      .RES_BIT(RES_BIT)
    ) u_requant (
      .sum_i  (sum_data[gi*OUT_BIT +: OUT_BIT]),
      .shift_i(shift_eff),
      .res_o  (res_lanes[gi*RES_BIT +: RES_BIT])
    );
  end

  // Next-state: drain handshake first, then an accept may start/continue/finish a tile.
  always_comb begin
    state_d     = state_q;
    pass_cnt_d  = pass_cnt_q;
    acc_d       = acc_q;
    passes_d    = passes_q;
    shift_d     = shift_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
      state_d     = ACCUM;
    end

    if (accept) begin
      // The tree already added inter_data, so the sum is simply loaded.
      acc_d = sum_data;
      if (first_pass) begin
        passes_d = cfg_passes_norm;
        shift_d  = cfg_shift;
      end
      if (last_pass) begin
        res_data_d  = res_lanes;
        res_valid_d = 1'b1;
        pass_cnt_d  = '0;
        state_d     = DRAIN;
      end else begin
        pass_cnt_d = pass_cnt_q + 1'b1;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      pass_cnt_q  <= '0;
      acc_q       <= '0;
      passes_q    <= PASS_W'(1);
      shift_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_cnt_q  <= pass_cnt_d;
      acc_q       <= acc_d;
      passes_q    <= passes_d;
      shift_q     <= shift_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator. The bench plays the adder tree: it keeps its
// own per-lane running totals and forms each sum as total + random partial.
// Expected results come from integer division arithmetic (floor, optional
// round-half-up under PSUM_ROUND_EN) followed by clamping.
module tb_psum_accumulator;

  localparam int MX = 8;
  localparam int MY = 8;
  localparam int L  = MX * MY;
  localparam int OB = 32;
  localparam int RB = 16;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [PW-1:0]     cfg_passes;
  logic [4:0]        cfg_shift;
  logic              sum_valid;
  logic [L*OB-1:0]   sum_data;
  logic              sum_ready;
  logic [L*OB-1:0]   inter_data;
  logic              res_valid;
  logic [L*RB-1:0]   res_data;
  logic              res_ready;
  logic              busy;

  int tests_run = 0;
  int failed    = 0;
  longint model_acc [L];

  always #5 clk = ~clk;

  psum_accumulator #(
    .MESH_X(MX), .MESH_Y(MY), .OUT_BIT(OB), .RES_BIT(RB), .PASS_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_passes(cfg_passes), .cfg_shift(cfg_shift),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_ready(sum_ready),
    .inter_data(inter_data),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference requantization: x / 2^sh rounded down (or half-up), then clamped.
  function automatic longint ref_requant(input longint x, input int sh);
    longint d, q, hi, lo;
    d = longint'(1) << sh;
`ifdef PSUM_ROUND_EN
    if (sh > 0) x = x + d / 2;
`endif
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    hi = (longint'(1) << (RB - 1)) - 1;
    lo = -(longint'(1) << (RB - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  function automatic logic [L*RB-1:0] exp_res(input logic [L*OB-1:0] s, input int sh);
    logic [L*RB-1:0] o;
    longint r;
    for (int i = 0; i < L; i++) begin
      r = ref_requant(longint'($signed(s[i*OB +: OB])), sh);
      o[i*RB +: RB] = r[RB-1:0];
    end
    return o;
  endfunction

  function automatic logic [OB-1:0] rnd_part();
    logic signed [OB-1:0] v;
    v = $urandom;
    v = v >>> $urandom_range(0, 24);
    return v;
  endfunction

  function automatic logic [L*OB-1:0] rnd_bus();
    logic [L*OB-1:0] b;
    for (int i = 0; i < L; i++) b[i*OB +: OB] = rnd_part();
    return b;
  endfunction

  // Present one beat and let it be accepted on the next rising edge.
  task automatic beat(input logic [L*OB-1:0] d);
    sum_valid = 1'b1;
    sum_data  = d;
    @(posedge clk); #1;
    sum_valid = 1'b0;
  endtask

  // One full tile with random partials; checks inter_data each pass and the result.
  task automatic run_tile(input int cfg_p, input int sh);
    logic [L*OB-1:0] d, exp_inter;
    logic [L*RB-1:0] er;
    int n;
    n = (cfg_p == 0) ? 1 : cfg_p;
    cfg_passes = PW'(cfg_p);
    cfg_shift  = 5'(sh);
    for (int p = 0; p < n; p++) begin
      for (int l = 0; l < L; l++) begin
        exp_inter[l*OB +: OB] = (p == 0) ? '0 : OB'(model_acc[l]);
        d[l*OB +: OB] = OB'(((p == 0) ? 64'sd0 : model_acc[l]) + longint'($signed(rnd_part())));
      end
      tests_run++;
      if (inter_data !== exp_inter) begin
        failed++;
        $display("FAIL inter_data passes=%0d pass %0d: lane0 got %0d want %0d (bus differs)",
                 cfg_p, p, $signed(inter_data[OB-1:0]), $signed(exp_inter[OB-1:0]));
      end
      for (int l = 0; l < L; l++) model_acc[l] = longint'($signed(d[l*OB +: OB]));
      beat(d);
    end
    er = exp_res(d, sh);
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== er) begin
      failed++;
      $display("FAIL tile_result passes=%0d shift=%0d: valid %b lane0 got %0d want %0d",
               cfg_p, sh, res_valid, $signed(res_data[RB-1:0]), $signed(er[RB-1:0]));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; sum_valid = 1'b0; sum_data = '0; res_ready = 1'b1;
    cfg_passes = PW'(1); cfg_shift = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (res_valid !== 1'b0) begin failed++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (inter_data !== '0) begin failed++; $display("FAIL reset_inter: lane0 got %0d want 0", inter_data[OB-1:0]); end
    tests_run++;
    if (res_data !== '0) begin failed++; $display("FAIL reset_res_data: lane0 got %0d want 0", res_data[RB-1:0]); end
    tests_run++;
    if (sum_ready !== 1'b1) begin failed++; $display("FAIL reset_sum_ready: got %b want 1", sum_ready); end
  endtask

  task automatic test_four_pass();
    int sums [4] = '{10, 30, 60, 100};
    int inters [4] = '{0, 10, 30, 60};
    logic [L*OB-1:0] d;
    d = '0;
    cfg_passes = PW'(4); cfg_shift = 5'd0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ($signed(inter_data[OB-1:0]) !== OB'(inters[k])) begin
        failed++;
        $display("FAIL four_pass_inter[%0d]: got %0d want %0d", k, $signed(inter_data[OB-1:0]), inters[k]);
      end
      d[OB-1:0] = OB'(sums[k]);
      beat(d);
      if (k == 2) begin
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
          failed++;
          $display("FAIL four_pass_midtile: res_valid %b busy %b want 0 1", res_valid, busy);
        end
      end
    end
    tests_run++;
    if (res_valid !== 1'b1 || $signed(res_data[RB-1:0]) !== 16'sd100) begin
      failed++;
      $display("FAIL four_pass_result: valid %b got %0d want 100", res_valid, $signed(res_data[RB-1:0]));
    end
  endtask

  task automatic test_round();
    logic [L*OB-1:0] d;
    logic signed [RB-1:0] e0, e1;
`ifdef PSUM_ROUND_EN
    e0 = -16'sd2; e1 = 16'sd3;
`else
    e0 = -16'sd3; e1 = 16'sd2;
`endif
    d = '0;
    d[0 +: OB]  = -32'sd37;
    d[OB +: OB] = 32'sd40;
    cfg_passes = PW'(1); cfg_shift = 5'd4;
    beat(d);
    tests_run++;
    if ($signed(res_data[0 +: RB]) !== e0) begin
      failed++; $display("FAIL round_neg37: got %0d want %0d", $signed(res_data[0 +: RB]), e0);
    end
    tests_run++;
    if ($signed(res_data[RB +: RB]) !== e1) begin
      failed++; $display("FAIL round_pos40: got %0d want %0d", $signed(res_data[RB +: RB]), e1);
    end
  endtask

  task automatic test_saturation();
    logic [L*OB-1:0] d;
    logic [RB-1:0] want [5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    d = '0;
    d[0*OB +: OB] = 32'h0001_0000;
    d[1*OB +: OB] = 32'hFFFE_0000;
    d[2*OB +: OB] = 32'h0000_7FFF;
    d[3*OB +: OB] = 32'hFFFF_8000;
    d[4*OB +: OB] = 32'h0000_8000;
    cfg_passes = PW'(1); cfg_shift = 5'd0;
    beat(d);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (res_data[i*RB +: RB] !== want[i]) begin
        failed++;
        $display("FAIL saturation_lane%0d: got %h want %h", i, res_data[i*RB +: RB], want[i]);
      end
    end
  endtask

  task automatic test_random_tiles();
    run_tile(3, 0);
    run_tile(2, 31);
    for (int t = 0; t < 8; t++) run_tile($urandom_range(1, 4), $urandom_range(0, 31));
  endtask

  task automatic test_back_to_back();
    logic [L*OB-1:0] d;
    logic [L*RB-1:0] er;
    res_ready = 1'b1;
    @(posedge clk); #1;
    cfg_passes = PW'(1); cfg_shift = 5'd2;
    sum_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d = rnd_bus();
      sum_data = d;
      @(posedge clk); #1;
      er = exp_res(d, 2);
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== er) begin
        failed++;
        $display("FAIL b2b_beat%0d: valid %b lane0 got %0d want %0d", k, res_valid,
                 $signed(res_data[RB-1:0]), $signed(er[RB-1:0]));
      end
    end
    res_ready = 1'b0;
    sum_data  = rnd_bus();
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (sum_ready !== 1'b0) begin failed++; $display("FAIL b2b_stall_ready%0d: got %b want 0", k, sum_ready); end
      @(posedge clk); #1;
      tests_run++;
      if (res_valid !== 1'b1 || res_data !== er) begin
        failed++;
        $display("FAIL b2b_stall_hold%0d: valid %b lane0 got %0d want %0d", k, res_valid,
                 $signed(res_data[RB-1:0]), $signed(er[RB-1:0]));
      end
    end
    sum_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (res_valid !== 1'b0) begin failed++; $display("FAIL b2b_drain: res_valid got %b want 0", res_valid); end
  endtask

  task automatic test_ena_low();
    logic [L*OB-1:0] d;
    logic [L*RB-1:0] er;
    res_ready = 1'b0;
    cfg_passes = PW'(1); cfg_shift = 5'd0;
    d = rnd_bus();
    beat(d);
    er = exp_res(d, 0);
    ena = 1'b0;
    sum_valid = 1'b1;
    sum_data = rnd_bus();
    #1;
    tests_run++;
    if (sum_ready !== 1'b0) begin failed++; $display("FAIL ena_low_ready: got %b want 0", sum_ready); end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (res_valid !== 1'b1 || res_data !== er || busy !== 1'b1) begin
      failed++;
      $display("FAIL ena_low_hold: valid %b busy %b lane0 got %0d want %0d", res_valid, busy,
               $signed(res_data[RB-1:0]), $signed(er[RB-1:0]));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL ena_low_handshake: valid %b busy %b want 0 0", res_valid, busy);
    end
    sum_valid = 1'b0;
    ena = 1'b1;
  endtask

  task automatic test_reset_mid_tile();
    res_ready = 1'b1;
    cfg_passes = PW'(3); cfg_shift = 5'd0;
    beat(rnd_bus());
    beat(rnd_bus());
    tests_run++;
    if (busy !== 1'b1) begin failed++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || inter_data !== '0) begin
      failed++;
      $display("FAIL midreset_async: busy %b valid %b inter lane0 %0d want 0 0 0", busy, res_valid,
               $signed(inter_data[OB-1:0]));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_tile(3, 0);
  endtask

  task automatic test_cfg();
    logic [L*OB-1:0] d;
    int sums [4] = '{1, 3, 6, 10};
    run_tile(0, 5);
    d = '0;
    cfg_passes = PW'(4); cfg_shift = 5'd0;
    for (int k = 0; k < 4; k++) begin
      d[OB-1:0] = OB'(sums[k]);
      beat(d);
      if (k == 0) begin
        cfg_passes = PW'(2);
        cfg_shift  = 5'd3;
      end
      if (k == 1 || k == 2) begin
        tests_run++;
        if (res_valid !== 1'b0) begin
          failed++; $display("FAIL cfg_change_early_done accept%0d: res_valid %b want 0", k + 1, res_valid);
        end
      end
    end
    tests_run++;
    if (res_valid !== 1'b1 || $signed(res_data[RB-1:0]) !== 16'sd10) begin
      failed++;
      $display("FAIL cfg_change_result: valid %b got %0d want 10", res_valid, $signed(res_data[RB-1:0]));
    end
  endtask

  initial begin
    test_reset();
    test_four_pass();
    test_round();
    test_saturation();
    test_random_tiles();
    test_back_to_back();
    test_ena_low();
    test_reset_mid_tile();
    test_cfg();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
